// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first, one bit per clock.
// A single full-subtractor cell and a 1-bit borrow register process the operands
// over WIDTH cycles. The registered result is published only when the last bit
// completes.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        request a subtraction (accepted in idle or in the done cycle)
//   a_i, b_i       minuend / subtrahend, sampled on the accepting edge only
//   busy_o         high while bits are being shifted
//   done_o         one-cycle pulse when diff_o / borrow_out_o are freshly valid
//   diff_o         (a - b) mod 2^WIDTH
//   borrow_out_o   final borrow, high iff a < b
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_out_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  // a_q doubles as the result accumulator: difference bits enter at the MSB
  // while minuend bits leave at the LSB.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic accept;
  logic last_bit;
  logic d_bit;
  logic br_next;

  assign accept   = start_i && (state_q != StShift);
  assign last_bit = (state_q == StShift) && (cnt_q == LastBit);

  // Full-subtractor cell on the current LSBs.
  assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = start_i ? StShift : StIdle;
      StShift: state_d = last_bit ? StDone : StShift;
      StDone:  state_d = start_i ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o       = (state_q == StShift);
    done_o       = (state_q == StDone);
    diff_o       = diff_q;
    borrow_out_o = borrow_q;
  end

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (accept) begin
      a_d   = a_i;
      b_d   = b_i;
      cnt_d = '0;
      br_d  = 1'b0;
    end else if (state_q == StShift) begin
      a_d   = {d_bit, a_q[WIDTH-1:1]};
      b_d   = {1'b0, b_q[WIDTH-1:1]};
      cnt_d = cnt_q + CntW'(1);
      br_d  = br_next;
      if (last_bit) begin
        diff_d   = {d_bit, a_q[WIDTH-1:1]};
        borrow_d = br_next;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8). Expected results are
// queued when a start is driven and popped by a monitor on each done pulse.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] diff_o;
  logic         borrow_out_o;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .diff_o       (diff_o),
    .borrow_out_o (borrow_out_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic         br;
    logic [W-1:0] d;
  } exp_t;

  exp_t         exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           done_cnt = 0;
  logic [W-1:0] hold_d = '0;
  logic         hold_br = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.d  = a - b;
    e.br = (a < b);
    return e;
  endfunction

  // Scoreboard: every done pulse consumes one queued expectation.
  always @(negedge clk_i) begin
    if (done_o === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 32'(done_o), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("diff", 32'(diff_o), 32'(e.d));
        check_val("borrow", 32'(borrow_out_o), 32'(e.br));
      end
    end
  end

  // Wait (bounded) for the next done pulse; returns negedges elapsed.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (done_o !== 1'b1 && n < 30);
    if (done_o !== 1'b1) check_val("done_timeout", 32'(done_o), 32'd1);
  endtask

  // One isolated operation with latency, busy-length and output-hold checks.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int   n;
    int   nb;
    exp_t e;
    @(negedge clk_i);
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    e       = model(a, b);
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    a_i     = W'($urandom);
    b_i     = W'($urandom);
    n  = 0;
    nb = 0;
    do begin
      @(negedge clk_i);
      n++;
      if (busy_o === 1'b1) nb++;
      if (done_o !== 1'b1) begin
        check_val("hold_diff", 32'(diff_o), 32'(hold_d));
        check_val("hold_borrow", 32'(borrow_out_o), 32'(hold_br));
      end
    end while (done_o !== 1'b1 && n < 30);
    check_val("done_latency", 32'(n), 32'(W + 1));
    check_val("busy_cycles", 32'(nb), 32'(W));
    hold_d  = e.d;
    hold_br = e.br;
  endtask

  initial begin
    int   n;
    int   base;
    exp_t e;

    rst_i   = 1'b1;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_done", 32'(done_o), 32'd0);
    check_val("rst_diff", 32'(diff_o), 32'd0);
    check_val("rst_borrow", 32'(borrow_out_o), 32'd0);
    rst_i = 1'b0;

    // Directed operand pairs
    run_op(8'd5, 8'd3);
    run_op(8'h00, 8'h01);
    run_op(8'hA5, 8'hA5);
    run_op(8'hFF, 8'h00);
    run_op(8'h00, 8'hFF);

    // Start during SHIFT is ignored
    @(negedge clk_i);
    a_i     = 8'h10;
    b_i     = 8'h01;
    start_i = 1'b1;
    exp_q.push_back(model(8'h10, 8'h01));
    base = done_cnt;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    start_i = 1'b1;
    a_i     = 8'h00;
    b_i     = 8'hFF;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_done(n);
    repeat (12) @(negedge clk_i);
    check_val("ignored_start_dones", 32'(done_cnt - base), 32'd1);
    check_val("ignored_start_busy", 32'(busy_o), 32'd0);
    check_val("ignored_start_diff", 32'(diff_o), 32'h0F);
    hold_d  = 8'h0F;
    hold_br = 1'b0;

    // Reset in SHIFT cycle 4 aborts with no done pulse
    @(negedge clk_i);
    a_i     = 8'h80;
    b_i     = 8'h01;
    start_i = 1'b1;
    base    = done_cnt;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_val("abort_busy", 32'(busy_o), 32'd0);
    check_val("abort_done", 32'(done_o), 32'd0);
    check_val("abort_diff", 32'(diff_o), 32'd0);
    check_val("abort_borrow", 32'(borrow_out_o), 32'd0);
    repeat (12) @(negedge clk_i);
    check_val("abort_no_done", 32'(done_cnt - base), 32'd0);
    hold_d  = '0;
    hold_br = 1'b0;

    // Reset wins over start on the same edge
    @(negedge clk_i);
    rst_i   = 1'b1;
    start_i = 1'b1;
    a_i     = 8'h33;
    b_i     = 8'h11;
    base    = done_cnt;
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    check_val("rst_prio_busy", 32'(busy_o), 32'd0);
    repeat (12) @(negedge clk_i);
    check_val("rst_prio_no_done", 32'(done_cnt - base), 32'd0);

    // First start after reset behaves normally
    run_op(8'h40, 8'h41);

    // start held high: back-to-back results every W+1 cycles
    @(negedge clk_i);
    a_i     = 8'h03;
    b_i     = 8'h05;
    start_i = 1'b1;
    base    = done_cnt;
    e       = model(8'h03, 8'h05);
    repeat (3) exp_q.push_back(e);
    for (int k = 0; k < 3; k++) begin
      wait_done(n);
      check_val("b2b_period", 32'(n), 32'(W + 1));
      if (k == 1) begin
        @(posedge clk_i);
        #1 start_i = 1'b0;
      end
    end
    repeat (12) @(negedge clk_i);
    check_val("b2b_dones", 32'(done_cnt - base), 32'd3);
    hold_d  = e.d;
    hold_br = e.br;

    // Random operand pairs
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom));
    end

    repeat (4) @(negedge clk_i);
    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
